// File: rtl/disp_bcd_snap.sv
// Snapshots ACC, B and the operand on each T6 rise and converts them to ASCII decimal
// text for the LCD renderer. One serial double-dabble engine is shared by all three values.
module disp_bcd_snap #(
  parameter bit LZB     = 1'b1,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        reset_btn,
  input  logic        T6,
  input  logic [7:0]  Dout_ACC,
  input  logic [7:0]  Dout_B,
  input  logic [7:0]  operand,
  input  logic        operand_blank,
  output logic [23:0] A_text,
  output logic [23:0] B_text,
  output logic [23:0] OPND_text,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  // state  | meaning
  // IDLE   | waiting for a T6 rise
  // CONV   | 24 double-dabble steps: ACC, then B, then operand (8 each)
  // COMMIT | load all text registers at once, pulse done, chain a pending request
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state;
  logic        t6_edge;
  logic [19:0] sr;
  logic [19:0] sr_nxt;
  logic [4:0]  cnt;
  logic [7:0]  w_b, w_opnd;
  logic        w_blank;
  logic [11:0] st_a, st_b, st_o;
  logic [7:0]  p_acc, p_b, p_opnd;
  logic        p_blank, pending;
  logic [7:0]  src_acc, src_b, src_opnd;
  logic        src_blank;

  if (SYNC_EN) begin : g_sync
    logic s1, s2, s3;
    always_ff @(posedge CLK or posedge reset_btn) begin
      if (reset_btn) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        s3 <= 1'b0;
      end else begin
        s1 <= T6;
        s2 <= s1;
        s3 <= s2;
      end
    end
    assign t6_edge = s2 & ~s3;
  end else begin : g_nosync
    logic s3;
    always_ff @(posedge CLK or posedge reset_btn) begin
      if (reset_btn) s3 <= 1'b0;
      else           s3 <= T6;
    end
    assign t6_edge = T6 & ~s3;
  end

  function automatic logic [19:0] dd_step(input logic [19:0] r);
    logic [19:0] t;
    t = r;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [23:0] to_text(input logic [11:0] d, input logic blank);
    logic [7:0] h, t, o;
    h = {4'h3, d[11:8]};
    t = {4'h3, d[7:4]};
    o = {4'h3, d[3:0]};
    if (LZB && d[11:8] == 4'd0) h = 8'h20;
    if (LZB && d[11:4] == 8'd0) t = 8'h20;
    if (blank) return 24'h202020;
    return {h, t, o};
  endfunction

  always_comb begin
    sr_nxt = dd_step(sr);
  end

  // Outside COMMIT-with-pending, a new request always comes straight from the inputs;
  // an edge landing on the COMMIT cycle is newer than the pending snapshot and wins.
  always_comb begin
    src_acc   = Dout_ACC;
    src_b     = Dout_B;
    src_opnd  = operand;
    src_blank = operand_blank;
    if (state == COMMIT && !t6_edge) begin
      src_acc   = p_acc;
      src_b     = p_b;
      src_opnd  = p_opnd;
      src_blank = p_blank;
    end
  end

  always_ff @(posedge CLK or posedge reset_btn) begin
    if (reset_btn) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      w_b       <= '0;
      w_opnd    <= '0;
      w_blank   <= 1'b0;
      st_a      <= '0;
      st_b      <= '0;
      st_o      <= '0;
      p_acc     <= '0;
      p_b       <= '0;
      p_opnd    <= '0;
      p_blank   <= 1'b0;
      pending   <= 1'b0;
      A_text    <= 24'h202020;
      B_text    <= 24'h202020;
      OPND_text <= 24'h202020;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (t6_edge) begin
            sr      <= {12'd0, src_acc};
            w_b     <= src_b;
            w_opnd  <= src_opnd;
            w_blank <= src_blank;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          if (t6_edge) begin
            p_acc   <= Dout_ACC;
            p_b     <= Dout_B;
            p_opnd  <= operand;
            p_blank <= operand_blank;
            pending <= 1'b1;
            if (pending) overrun <= 1'b1;
          end
          cnt <= cnt + 5'd1;
          if (cnt[2:0] == 3'd7) begin
            case (cnt[4:3])
              2'd0: begin
                st_a <= sr_nxt[19:8];
                sr   <= {12'd0, w_b};
              end
              2'd1: begin
                st_b <= sr_nxt[19:8];
                sr   <= {12'd0, w_opnd};
              end
              default: st_o <= sr_nxt[19:8];
            endcase
          end else begin
            sr <= sr_nxt;
          end
          if (cnt == 5'd23) state <= COMMIT;
        end
        COMMIT: begin
          A_text    <= to_text(st_a, 1'b0);
          B_text    <= to_text(st_b, 1'b0);
          OPND_text <= to_text(st_o, w_blank);
          done      <= 1'b1;
          if (t6_edge || pending) begin
            if (t6_edge && pending) overrun <= 1'b1;
            sr      <= {12'd0, src_acc};
            w_b     <= src_b;
            w_opnd  <= src_opnd;
            w_blank <= src_blank;
            cnt     <= '0;
            pending <= 1'b0;
            state   <= CONV;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_bcd_snap.sv
// Scoreboard bench: three instances (default, LZB=0, SYNC_EN=0) share one stimulus stream;
// a reference model of request arrival/pending/overrun predicts text and done timing.
module tb_disp_bcd_snap;

  logic        CLK = 1'b0;
  logic        reset_btn, T6, opnd_blank;
  logic [7:0]  acc, bval, opnd;
  logic [23:0] a_txt [3];
  logic [23:0] b_txt [3];
  logic [23:0] o_txt [3];
  logic        busy [3];
  logic        done [3];
  logic        ovr [3];

  disp_bcd_snap #(.LZB(1'b1), .SYNC_EN(1'b1)) u_main (
    .CLK(CLK), .reset_btn(reset_btn), .T6(T6), .Dout_ACC(acc), .Dout_B(bval),
    .operand(opnd), .operand_blank(opnd_blank), .A_text(a_txt[0]), .B_text(b_txt[0]),
    .OPND_text(o_txt[0]), .busy(busy[0]), .done(done[0]), .overrun(ovr[0]));

  disp_bcd_snap #(.LZB(1'b0), .SYNC_EN(1'b1)) u_lz0 (
    .CLK(CLK), .reset_btn(reset_btn), .T6(T6), .Dout_ACC(acc), .Dout_B(bval),
    .operand(opnd), .operand_blank(opnd_blank), .A_text(a_txt[1]), .B_text(b_txt[1]),
    .OPND_text(o_txt[1]), .busy(busy[1]), .done(done[1]), .overrun(ovr[1]));

  disp_bcd_snap #(.LZB(1'b1), .SYNC_EN(1'b0)) u_sync0 (
    .CLK(CLK), .reset_btn(reset_btn), .T6(T6), .Dout_ACC(acc), .Dout_B(bval),
    .operand(opnd), .operand_blank(opnd_blank), .A_text(a_txt[2]), .B_text(b_txt[2]),
    .OPND_text(o_txt[2]), .busy(busy[2]), .done(done[2]), .overrun(ovr[2]));

  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] o;
    int          due;
  } exp_t;

  exp_t sbq [3][$];
  int   errors = 0;
  int   checks = 0;
  int   last_start [3];
  bit   last_pend [3];
  bit   m_ovr [3];
  bit   lzb_of [3] = '{1'b1, 1'b0, 1'b1};
  int   lat_of [3] = '{2, 2, 0};
  int   busy_run [3] = '{0, 0, 0};
  int   last_run [3] = '{0, 0, 0};
  int   rise_cyc;

  function automatic logic [23:0] ref_text(input int v, input bit lzb, input bit blank);
    int h, t, o;
    logic [7:0] hc, tc, oc;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    hc = (lzb && h == 0) ? 8'h20 : 8'(48 + h);
    tc = (lzb && h == 0 && t == 0) ? 8'h20 : 8'(48 + t);
    oc = 8'(48 + o);
    if (blank) return 24'h202020;
    return {hc, tc, oc};
  endfunction

  // A request seen at edge d starts at d if idle, otherwise when the current conversion
  // commits; a second request waiting for the same slot replaces the first and flags overrun.
  task automatic model_push(input int k, input int d, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] o, input logic bl);
    exp_t e;
    e.a = ref_text(int'(a), lzb_of[k], 1'b0);
    e.b = ref_text(int'(b), lzb_of[k], 1'b0);
    e.o = ref_text(int'(o), lzb_of[k], bl);
    if (d > last_start[k] + 25) begin
      last_start[k] = d;
      last_pend[k]  = 1'b0;
      e.due = d + 25;
      sbq[k].push_back(e);
    end else if (last_pend[k] && last_start[k] >= d) begin
      e.due = last_start[k] + 25;
      sbq[k][sbq[k].size() - 1] = e;
      m_ovr[k] = 1'b1;
    end else begin
      last_start[k] = last_start[k] + 25;
      last_pend[k]  = 1'b1;
      e.due = last_start[k] + 25;
      sbq[k].push_back(e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      sbq[k].delete();
      last_start[k] = -1000;
      last_pend[k]  = 1'b0;
      m_ovr[k]      = 1'b0;
    end
  endtask

  task automatic req(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o, input logic bl);
    @(negedge CLK);
    acc = a; bval = b; opnd = o; opnd_blank = bl;
    T6 = 1'b1;
    rise_cyc = cyc;
    for (int k = 0; k < 3; k++) model_push(k, cyc + 1 + lat_of[k], a, b, o, bl);
    repeat (3) @(negedge CLK);
    T6 = 1'b0;
    acc = 8'($urandom); bval = 8'($urandom); opnd = 8'($urandom); opnd_blank = 1'($urandom);
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && i < 400) begin
      @(negedge CLK);
      i++;
    end
    checks++;
    if (i >= 400) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d/%0d/%0d required=0", sbq[0].size(), sbq[1].size(), sbq[2].size());
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_ovr(input string tag);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ovr[k] !== m_ovr[k]) begin
        errors++;
        $display("FAIL %s_overrun dut%0d got=%0b required=%0b", tag, k, ovr[k], m_ovr[k]);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({a_txt[k], b_txt[k], o_txt[k], busy[k], done[k], ovr[k]} !== {72'h202020202020202020, 3'b000}) begin
        errors++;
        $display("FAIL %s dut%0d got=%h/%h/%h busy=%0b done=%0b ovr=%0b required=202020 x3, 0/0/0",
                 tag, k, a_txt[k], b_txt[k], o_txt[k], busy[k], done[k], ovr[k]);
      end
    end
  endtask

  task automatic check_busy_run(input string tag, input int want);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (last_run[k] != want) begin
        errors++;
        $display("FAIL %s_busy_len dut%0d got=%0d required=%0d", tag, k, last_run[k], want);
      end
    end
  endtask

  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      if (busy[k] === 1'b1) busy_run[k] = busy_run[k] + 1;
      else begin
        if (busy_run[k] != 0) last_run[k] = busy_run[k];
        busy_run[k] = 0;
      end
      if (done[k] === 1'b1) begin
        checks++;
        if (sbq[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_done dut%0d cyc=%0d got=%h/%h/%h required=no_done",
                   k, cyc, a_txt[k], b_txt[k], o_txt[k]);
        end else begin
          exp_t e;
          e = sbq[k].pop_front();
          if ({a_txt[k], b_txt[k], o_txt[k]} !== {e.a, e.b, e.o}) begin
            errors++;
            $display("FAIL text dut%0d cyc=%0d got=%h/%h/%h required=%h/%h/%h",
                     k, cyc, a_txt[k], b_txt[k], o_txt[k], e.a, e.b, e.o);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL done_time dut%0d got=%0d required=%0d", k, cyc, e.due);
          end
        end
      end
    end
  end

  initial begin
    reset_btn = 1'b1; T6 = 1'b0;
    acc = 8'd0; bval = 8'd0; opnd = 8'd0; opnd_blank = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_reset_state("reset_state");
    reset_btn = 1'b0;
    repeat (3) @(negedge CLK);

    req(8'd255, 8'd7, 8'd40, 1'b0);
    wait_idle();
    check_busy_run("single", 25);

    req(8'd0, 8'd100, 8'd9, 1'b0);
    wait_idle();
    check_busy_run("zeros", 25);

    req(8'd37, 8'd200, 8'hFF, 1'b1);
    wait_idle();
    check_ovr("no_chain");

    req(8'd12, 8'd1, 8'd2, 1'b0);
    repeat (4) @(negedge CLK);
    req(8'd99, 8'd3, 8'd4, 1'b0);
    wait_idle();
    check_ovr("chain");

    req(8'd10, 8'd20, 8'd30, 1'b0);
    req(8'd11, 8'd21, 8'd31, 1'b0);
    req(8'd199, 8'd5, 8'd250, 1'b0);
    wait_idle();
    check_ovr("triple");

    req(8'd123, 8'd45, 8'd6, 1'b0);
    while (cyc < rise_cyc + 3 + 12) @(negedge CLK);
    reset_btn = 1'b1;
    model_reset();
    #1;
    check_reset_state("midconv_reset");
    @(negedge CLK);
    reset_btn = 1'b0;
    repeat (3) @(negedge CLK);
    req(8'd86, 8'd150, 8'd0, 1'b0);
    wait_idle();

    for (int n = 0; n < 24; n++) begin
      req(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 30)) @(negedge CLK);
    end
    wait_idle();
    check_ovr("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_bcd_snap.md
Name: disp_bcd_snap

Overview:
- Sequential display-formatting stage that sits between the CPU8 core and the LCD text renderer.
- On each rising edge of the CPU's T6 phase it snapshots ACC, B and the instruction operand.
- Converts each 8-bit value to three decimal ASCII characters using a shared serial double-dabble engine, replacing the combinational %/÷ logic.
- Presents all nine characters to the renderer in one atomic update, with a done pulse.

Parameters:
- LZB, 1: leading-zero blanking. 1 = leading zero digits become 0x20; 0 = always three digits.
- SYNC_EN, 1: 1 = T6 passes through a 2-flop synchroniser before edge detection; 0 = single registered stage (T6 already CLK-synchronous).

Ports:
- CLK  in  1  system clock, 50 MHz
- reset_btn  in  1  asynchronous, active-high reset
- T6  in  1  CPU phase strobe, level, may be asynchronous to CLK
- Dout_ACC  in  8  accumulator value, unsigned
- Dout_B  in  8  B register value, unsigned
- operand  in  8  instruction operand, unsigned
- operand_blank  in  1  1 = no operand (undriven bus or no-operand opcode); operand field shows spaces
- A_text  out  24  ACC characters; [23:16] hundreds, [15:8] tens, [7:0] ones, ASCII
- B_text  out  24  B characters, same layout
- OPND_text  out  24  operand characters, same layout
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse coincident with a text-register update
- overrun  out  1  sticky; set when a third T6 edge arrives while one request is already pending; cleared by reset only

Behaviour:
- Reset (async assert, sync release):
  - A_text, B_text, OPND_text = 24'h202020.
  - busy = 0, done = 0, overrun = 0.
  - FSM returns to IDLE; pending flag cleared.
  - Reset mid-conversion aborts with no output update.
- Edge detect:
  - SYNC_EN=1: s1 <= T6, s2 <= s1, s3 <= s2; edge = s2 & ~s3.
  - SYNC_EN=0: s3 <= T6; edge = T6 & ~s3.
- Snapshot: on a CLK edge where edge=1 and FSM is IDLE, capture Dout_ACC, Dout_B, operand and operand_blank into working registers, then go to CONV. This is edge k.
- FSM states:
  - IDLE -> CONV on edge (or on pending).
  - CONV: 24 cycles, 8 per value, in order ACC, B, operand.
  - CONV -> COMMIT after the 24th shift, at edge k+24.
  - COMMIT -> IDLE at edge k+25.
- Double-dabble step, one per cycle:
  - 20-bit shift register {hund[3:0], tens[3:0], ones[3:0], bin[7:0]}; hundreds digit is at most 2.
  - Any BCD nibble >= 5 gets +3, then the whole register shifts left by 1.
  - After 8 steps, the three digits go into the staging register for the current value.
- COMMIT, at edge k+25, all three text registers load together and done = 1 for exactly one cycle.
  - Character = 8'h30 + digit.
  - LZB=1: hundreds = 0x20 if 0; tens = 0x20 if hundreds == 0 and tens == 0; ones always a digit.
  - operand_blank captured = 1: OPND_text = 24'h202020 regardless of value.
- busy = 1 from edge k+1 through the COMMIT cycle; 0 in IDLE.
- Latency: T6 rise sampled at edge j -> capture at j+2 (SYNC_EN=1) or j (SYNC_EN=0); text updates 25 cycles after capture.
- T6 edge while busy:
  - Snapshot the inputs into pending registers and set pending.
  - A later edge while pending is already set overwrites the pending snapshot (latest wins) and sets overrun.
  - COMMIT with pending set goes straight to CONV using the pending snapshot, clears pending, and causes no IDLE cycle.
  - An edge in the same cycle as COMMIT counts as pending.
- Text registers never show a partial mix of old and new values.

Test Plan:
- Reset, then T6 rise with ACC=255, B=7, operand=40, blank=0, LZB=1 -> 27 cycles after the first sampled T6 high: A_text=24'h323535, B_text=24'h202037, OPND_text=24'h203430, done pulses once, busy high for 25 cycles.
- LZB=0, ACC=0, B=100, operand=9 -> A_text=24'h303030, B_text=24'h313030, OPND_text=24'h303039.
- operand_blank=1, operand=8'hFF -> OPND_text=24'h202020; A_text and B_text convert normally.
- Second T6 edge 10 cycles after the first (ACC 12 then 99) -> two done pulses 25 cycles apart, no IDLE gap; final A_text=24'h203939. A third edge inside the same window -> overrun=1 and the last snapshot is used.
- reset_btn asserted at CONV cycle 12 -> outputs immediately 24'h202020 / busy=0 / done=0; the next T6 edge converts cleanly.
- SYNC_EN=0 with a CLK-synchronous T6 -> capture on the same edge T6 is first sampled high; update after 25 cycles.
